// File: rtl/store_commit_ctrl_pkg.sv
// Shared types for the store commit path: exception record, store-queue entry,
// commit FSM states and the store alignment helpers.
package store_commit_ctrl_pkg;

    typedef struct packed {
        logic        ex;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
        logic        tlb_refill;
    } exception_t;

    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
    } sq_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } commit_state_e;

    // Word stores need addr[1:0]==0, halfword stores (two contiguous lanes) need addr[0]==0.
    function automatic logic is_misaligned(input sq_entry_t e);
        logic word_bad;
        logic half_bad;
        word_bad = (e.wstrb == 4'b1111) && (e.addr[1:0] != 2'b00);
        half_bad = ((e.wstrb == 4'b0011) || (e.wstrb == 4'b1100)) && e.addr[0];
        return word_bad || half_bad;
    endfunction

    function automatic exception_t ades_exception(input logic [31:0] vaddr);
        exception_t e;
        e.ex         = 1'b1;
        e.exccode    = EXC_ADES;
        e.badvaddr   = vaddr;
        e.tlb_refill = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/store_commit_ctrl_if.sv
// Store-queue push, commit handshake and dcache write channel of store_commit_ctrl.
// The slave modport is the controller side; master is the pipeline/cache side.
interface store_commit_ctrl_if;
    import store_commit_ctrl_pkg::*;

    logic        sq_push_valid;
    logic [31:0] sq_push_addr;
    logic [31:0] sq_push_data;
    logic [3:0]  sq_push_wstrb;
    logic        sq_full;

    logic        commit_store_valid;
    logic        commit_store_ready;
    exception_t  commit_store_ex;
    logic        flush;

    logic        data_req;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport slave (
        input  sq_push_valid, sq_push_addr, sq_push_data, sq_push_wstrb,
        input  commit_store_valid, flush, data_addr_ok, data_data_ok,
        output sq_full, commit_store_ready, commit_store_ex,
        output data_req, data_addr, data_wdata, data_wstrb
    );

    modport master (
        output sq_push_valid, sq_push_addr, sq_push_data, sq_push_wstrb,
        output commit_store_valid, flush, data_addr_ok, data_data_ok,
        input  sq_full, commit_store_ready, commit_store_ex,
        input  data_req, data_addr, data_wdata, data_wstrb
    );

endinterface

// File: rtl/store_commit_ctrl_store_queue.sv
// Circular store queue: program-ordered executed stores waiting for commit.
// Clear beats push and pop; a push while full is dropped even if a pop happens that cycle.
module store_queue
    import store_commit_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  sq_entry_t                  push_entry_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output sq_entry_t                  head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sq_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem[head_q];

    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && (count_q != '0) && !clear_i;

    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + PTR_W'(1);
            if (pop_ok)  head_d = head_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail_q] <= push_entry_i;
    end

endmodule

// File: rtl/store_commit_ctrl.sv
// Commit-time store controller: drains the store queue head to the dcache when commit asks.
// Optional build macro STORE_ALIGN_CHECK_EN raises AdES for misaligned heads without a bus request.
module store_commit_ctrl
    import store_commit_ctrl_pkg::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    store_commit_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(SQ_DEPTH) + 1;

    commit_state_e    state_q, state_d;
    exception_t       ex_q, ex_d;
    logic             flushed_q, flushed_d;
    sq_entry_t        push_entry;
    sq_entry_t        head_entry;
    logic [CNT_W-1:0] sq_count;
    logic             sq_empty;
    logic             misaligned;
    logic             pop;
    logic             ready;

    assign push_entry = '{addr: bus.sq_push_addr, data: bus.sq_push_data, wstrb: bus.sq_push_wstrb};

    store_queue #(
        .DEPTH (SQ_DEPTH)
    ) u_queue (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (bus.sq_push_valid),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .clear_i      (bus.flush),
        .head_o       (head_entry),
        .count_o      (sq_count),
        .full_o       (bus.sq_full)
    );

    assign sq_empty = (sq_count == '0);

`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(head_entry);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ex_q      <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ex_q      <= ex_d;
            flushed_q <= flushed_d;
        end
    end

    // flushed_q remembers a flush seen while the write is on the bus; the write still has
    // to finish, but it must retire silently.
    always_comb begin
        state_d   = state_q;
        ex_d      = ex_q;
        flushed_d = flushed_q;
        case (state_q)
            ST_IDLE: begin
                flushed_d = 1'b0;
                if (bus.commit_store_valid && !sq_empty && !bus.flush) begin
                    if (misaligned) begin
                        state_d = ST_DONE;
                        ex_d    = ades_exception(head_entry.addr);
                    end else begin
                        state_d = ST_REQ;
                        ex_d    = '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        state_d = bus.flush ? ST_IDLE : ST_DONE;
                    end else begin
                        state_d   = ST_WAIT;
                        flushed_d = bus.flush;
                    end
                end else if (bus.flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.data_data_ok) begin
                    state_d   = (flushed_q || bus.flush) ? ST_IDLE : ST_DONE;
                    flushed_d = 1'b0;
                end else if (bus.flush) begin
                    flushed_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pop   = (state_q == ST_DONE);
    assign ready = pop && !bus.flush;

    assign bus.commit_store_ready = ready;
    assign bus.commit_store_ex    = ready ? ex_q : '0;

    // Head stays stable during REQ: pops only happen in DONE and pushes land at the tail.
    assign bus.data_req   = (state_q == ST_REQ);
    assign bus.data_addr  = bus.data_req ? head_entry.addr  : '0;
    assign bus.data_wdata = bus.data_req ? head_entry.data  : '0;
    assign bus.data_wstrb = bus.data_req ? head_entry.wstrb : '0;

endmodule
